// File: rtl/core_pkg.sv
// Shared core types and constants for the fetch stage.
package core_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } fetch_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            misalign;
  } pend_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty and a flush that empties it.
module ifetch_fifo #(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   wdata,
  input  logic                     pop,
  output entry_t                   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t      mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count   = wptr_q - rptr_q;
  assign rdata   = mem_q[rptr_q[AW-1:0]];
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues imem requests under a credit limit, buffers in-order responses
// for decode, and drops wrong-path responses after a flush.
module ifetch_unit
  import core_pkg::*;
#(
  parameter int unsigned     DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            fetch_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_misalign,
  input  logic            instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] ent_count, pend_count;
  logic          ent_full, ent_empty, pend_full, pend_empty;
  logic          can_issue, grant, rsp_ok, drop, ent_push, ent_pop;
  fetch_entry_t  ent_wdata, ent_head;
  pend_entry_t   pend_wdata, pend_head;

  // Words still awaiting discard remain in outstanding, so they hold credit too.
  assign can_issue = (SW'(outstanding_q) + SW'(ent_count)) < SW'(DEPTH);
  assign imem_req  = can_issue & ~flush & ~rst;
  assign imem_addr = pc_in;
  assign grant     = imem_req & imem_gnt;
  assign fetch_stall = ~flush & ~grant & ~rst;

  // A response with nothing outstanding is illegal and ignored.
  assign rsp_ok   = imem_rvalid & (outstanding_q != '0);
  assign drop     = rsp_ok & (discard_q != '0);
  assign ent_push = rsp_ok & ~drop;
  assign ent_pop  = instr_valid & instr_ready;

  assign pend_wdata = '{pc: pc_in, misalign: (pc_in[1:0] != 2'b00)};
  assign ent_wdata  = '{word: imem_rdata, pc: pend_head.pc, misalign: pend_head.misalign};

  always_comb begin
    outstanding_d = outstanding_q + CW'(grant) - CW'(rsp_ok);
    discard_d     = discard_q - CW'(drop);
    if (flush) begin
      discard_d = (outstanding_d > CW'(DEPTH)) ? CW'(DEPTH) : outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  ifetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (pend_entry_t)
  ) u_pend_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (grant),
    .wdata (pend_wdata),
    .pop   (rsp_ok),
    .rdata (pend_head),
    .full  (pend_full),
    .empty (pend_empty),
    .count (pend_count)
  );

  ifetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_ent_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (ent_push),
    .wdata (ent_wdata),
    .pop   (ent_pop),
    .rdata (ent_head),
    .full  (ent_full),
    .empty (ent_empty),
    .count (ent_count)
  );

  assign instr_valid    = ~ent_empty;
  assign instr          = instr_valid ? ent_head.word : NOP_INSTR;
  assign instr_pc       = instr_valid ? ent_head.pc : '0;
  assign instr_misalign = instr_valid & ent_head.misalign;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && outstanding_q == '0))
        else $error("ifetch_unit: imem_rvalid with no outstanding request");
      assert (pend_count == outstanding_q)
        else $error("ifetch_unit: pending-PC queue out of step with outstanding count");
      assert (!(pend_empty && outstanding_q != '0))
        else $error("ifetch_unit: outstanding request without a pending PC");
      assert (!(grant && pend_full))
        else $error("ifetch_unit: grant with pending-PC queue full");
      assert (!(ent_push && ent_full && !ent_pop && !flush))
        else $error("ifetch_unit: entry queue overflow");
    end
  end

endmodule
